hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RV32 core (IF/ID/EX/M/WB). It sequences the EX datapath: generates the ID→EX hang-on and EX overwrite forwarding controls, inserts load-use bubbles, flushes on taken branches/jumps, and freezes the whole pipeline while data memory is busy. It sits beside the stage registers and drives their hold/flush inputs.

---
 rtl/hazard_ctrl_pkg.sv | 11 +
 rtl/hazard_match.sv | 16 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM states and x0-aware register-number match for hazard_ctrl.
`ifndef XLEN
`define XLEN 32
`endif
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FREEZE = 2'd2} state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (dst != REG_X0);
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one destination compared against two sources; x0 never matches.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] dst_num_i,
  input  logic       dst_en_i,
  input  logic [4:0] a_num_i,
  input  logic       a_en_i,
  input  logic [4:0] b_num_i,
  input  logic       b_en_i,
  output logic       a_hit_o,
  output logic       b_hit_o
);
  assign a_hit_o = dst_en_i & a_en_i & reg_hit(a_num_i, dst_num_i);
  assign b_hit_o = dst_en_i & b_en_i & reg_hit(b_num_i, dst_num_i);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use bubble, branch flush and memory freeze control.
// Optional HAZARD_PERF_EN adds stall/flush/freeze event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int XLEN = `XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      id_reg_anum,
  input  logic [4:0]      id_reg_bnum,
  input  logic            id_use_a,
  input  logic            id_use_b,
  input  logic [4:0]      ex_reg_anum,
  input  logic [4:0]      ex_reg_bnum,
  input  logic [4:0]      ex_reg_wnum,
  input  logic            ex_reg_wr,
  input  logic            ex_mem_load,
  input  logic            pcg_branch,
  input  logic [4:0]      m_reg_wnum,
  input  logic            m_reg_wr,
  input  logic            m_mem_load,
  input  logic [XLEN-1:0] m_aluresult,
  input  logic            m_mem_req,
  input  logic            mem_ready,
  input  logic [4:0]      wb_reg_wnum,
  input  logic            wb_reg_wr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_overwrite_ra,
  output logic            ex_overwrite_rb,
  output logic [XLEN-1:0] ex_over_data,
  output logic            id_ex_hangon_ra,
  output logic            id_ex_hangon_rb,
  output logic [XLEN-1:0] id_ex_over_data,
  output logic            pc_hold,
  output logic            if_id_hold,
  output logic            id_ex_hold,
  output logic            ex_m_hold,
  output logic            m_wb_hold,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     freeze_cnt
`endif
);
  state_e state_q, state_d;
  logic lu_a, lu_b, load_use, freeze, br_flush, bubble;
  hazard_match u_over (
    .dst_num_i(m_reg_wnum), .dst_en_i(m_reg_wr & ~m_mem_load),
    .a_num_i(ex_reg_anum), .a_en_i(1'b1), .b_num_i(ex_reg_bnum), .b_en_i(1'b1),
    .a_hit_o(ex_overwrite_ra), .b_hit_o(ex_overwrite_rb)
  );
  hazard_match u_hang (
    .dst_num_i(wb_reg_wnum), .dst_en_i(wb_reg_wr),
    .a_num_i(id_reg_anum), .a_en_i(id_use_a), .b_num_i(id_reg_bnum), .b_en_i(id_use_b),
    .a_hit_o(id_ex_hangon_ra), .b_hit_o(id_ex_hangon_rb)
  );
  hazard_match u_load (
    .dst_num_i(ex_reg_wnum), .dst_en_i(ex_reg_wr & ex_mem_load),
    .a_num_i(id_reg_anum), .a_en_i(id_use_a), .b_num_i(id_reg_bnum), .b_en_i(id_use_b),
    .a_hit_o(lu_a), .b_hit_o(lu_b)
  );
  assign ex_over_data    = m_aluresult;
  assign id_ex_over_data = wb_data;
  assign load_use        = lu_a | lu_b;
  // Priority freeze > branch > load-use; STALL already carries its one bubble.
  assign freeze   = ~rst & m_mem_req & ~mem_ready;
  assign br_flush = ~rst & ~freeze & pcg_branch;
  assign bubble   = ~rst & ~freeze & ~pcg_branch & load_use & (state_q != STALL);
  assign pc_hold     = freeze | bubble;
  assign if_id_hold  = freeze | bubble;
  assign id_ex_hold  = freeze;
  assign ex_m_hold   = freeze;
  assign m_wb_hold   = freeze;
  assign if_id_flush = br_flush;
  assign id_ex_flush = br_flush | bubble;
  assign state       = state_q;
  always_comb state_d = freeze ? FREEZE : bubble ? STALL : RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      stall_cnt  <= stall_cnt + 32'(bubble);
      flush_cnt  <= flush_cnt + 32'(br_flush);
      freeze_cnt <= freeze_cnt + 32'(freeze);
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding, bubbles, flushes, freeze and reset.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic clk = 0, rst = 1;
  logic [4:0] id_reg_anum, id_reg_bnum, ex_reg_anum, ex_reg_bnum, ex_reg_wnum, m_reg_wnum, wb_reg_wnum;
  logic id_use_a, id_use_b, ex_reg_wr, ex_mem_load, pcg_branch, m_reg_wr, m_mem_load;
  logic m_mem_req, mem_ready, wb_reg_wr;
  logic [31:0] m_aluresult, wb_data, ex_over_data, id_ex_over_data;
  logic ex_overwrite_ra, ex_overwrite_rb, id_ex_hangon_ra, id_ex_hangon_rb;
  logic pc_hold, if_id_hold, id_ex_hold, ex_m_hold, m_wb_hold, if_id_flush, id_ex_flush;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_reg_anum(id_reg_anum), .id_reg_bnum(id_reg_bnum),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .ex_reg_anum(ex_reg_anum), .ex_reg_bnum(ex_reg_bnum),
    .ex_reg_wnum(ex_reg_wnum), .ex_reg_wr(ex_reg_wr), .ex_mem_load(ex_mem_load), .pcg_branch(pcg_branch),
    .m_reg_wnum(m_reg_wnum), .m_reg_wr(m_reg_wr), .m_mem_load(m_mem_load), .m_aluresult(m_aluresult),
    .m_mem_req(m_mem_req), .mem_ready(mem_ready), .wb_reg_wnum(wb_reg_wnum), .wb_reg_wr(wb_reg_wr),
    .wb_data(wb_data), .ex_overwrite_ra(ex_overwrite_ra), .ex_overwrite_rb(ex_overwrite_rb),
    .ex_over_data(ex_over_data), .id_ex_hangon_ra(id_ex_hangon_ra), .id_ex_hangon_rb(id_ex_hangon_rb),
    .id_ex_over_data(id_ex_over_data), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .id_ex_hold(id_ex_hold), .ex_m_hold(ex_m_hold), .m_wb_hold(m_wb_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_reg_anum, id_reg_bnum, ex_reg_anum, ex_reg_bnum, ex_reg_wnum, m_reg_wnum, wb_reg_wnum} = '0;
    {id_use_a, id_use_b, ex_reg_wr, ex_mem_load, pcg_branch, m_reg_wr, m_mem_load} = '0;
    {m_mem_req, wb_reg_wr} = '0;
    mem_ready = 1;
    m_aluresult = 0;
    wb_data = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] ctl();
    return {pc_hold, if_id_hold, id_ex_hold, ex_m_hold, m_wb_hold, if_id_flush, id_ex_flush};
  endfunction
  initial begin
    idle();
    #3;
    chk("rst_ctl", 32'(ctl()), 0);
    chk("rst_state", 32'(state), 32'(RUN));
    m_mem_req = 1; mem_ready = 0; pcg_branch = 1;
    #1 chk("rst_gates_ctl", 32'(ctl()), 0);
    idle();
    step();
    rst = 0;
    step();
    ex_reg_anum = 3; ex_reg_bnum = 4; m_reg_wr = 1; m_reg_wnum = 3; m_aluresult = 32'h1234;
    #1 chk("ovr_ra", 32'(ex_overwrite_ra), 1);
    chk("ovr_rb", 32'(ex_overwrite_rb), 0);
    chk("ovr_data", ex_over_data, 32'h1234);
    chk("ovr_ctl", 32'(ctl()), 0);
    m_mem_load = 1;
    #1 chk("ovr_load", 32'(ex_overwrite_ra), 0);
    idle();
    m_reg_wr = 1; ex_reg_anum = 0; ex_reg_bnum = 0;
    wb_reg_wr = 1; id_reg_anum = 0; id_reg_bnum = 0; id_use_a = 1; id_use_b = 1;
    #1 chk("x0_ovr", 32'({ex_overwrite_ra, ex_overwrite_rb}), 0);
    chk("x0_hang", 32'({id_ex_hangon_ra, id_ex_hangon_rb}), 0);
    idle();
    wb_reg_wr = 1; wb_reg_wnum = 9; id_reg_anum = 9; id_use_a = 0; wb_data = 32'h55;
    #1 chk("hang_unused", 32'(id_ex_hangon_ra), 0);
    id_use_a = 1;
    #1 chk("hang_ra", 32'(id_ex_hangon_ra), 1);
    chk("hang_data", id_ex_over_data, 32'h55);
    idle();
    step();
    ex_reg_wr = 1; ex_mem_load = 1; ex_reg_wnum = 7; id_reg_bnum = 7; id_use_b = 1;
    #1 chk("lu_ctl", 32'(ctl()), 32'b1100001);
    step();
    chk("lu_state", 32'(state), 32'(STALL));
    ex_reg_wr = 0; ex_mem_load = 0; wb_reg_wr = 1; wb_reg_wnum = 7; wb_data = 32'hCAFE;
    #1 chk("lu_after_ctl", 32'(ctl()), 0);
    chk("lu_hang_rb", 32'(id_ex_hangon_rb), 1);
    chk("lu_hang_data", id_ex_over_data, 32'hCAFE);
    step();
    chk("lu_back_run", 32'(state), 32'(RUN));
    idle();
    ex_reg_wr = 1; ex_mem_load = 1; ex_reg_wnum = 7; id_reg_anum = 7; id_use_a = 1; pcg_branch = 1;
    #1 chk("br_lu_ctl", 32'(ctl()), 32'b0000011);
    step();
    chk("br_state", 32'(state), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 1);
    chk("flush_cnt", flush_cnt, 1);
`endif
    idle();
    m_mem_req = 1; mem_ready = 0; pcg_branch = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("frz_ctl%0d", i), 32'(ctl()), 32'b1111100);
      step();
      chk($sformatf("frz_state%0d", i), 32'(state), 32'(FREEZE));
    end
    mem_ready = 1;
    #1 chk("frz_exit_ctl", 32'(ctl()), 32'b0000011);
    step();
    chk("frz_exit_state", 32'(state), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("freeze_cnt", freeze_cnt, 3);
    chk("flush_cnt2", flush_cnt, 2);
`endif
    idle();
    m_mem_req = 1; mem_ready = 0;
    step();
    chk("rst_frz_pre", 32'(state), 32'(FREEZE));
    #1 rst = 1;
    #1 chk("rst_frz_ctl", 32'(ctl()), 0);
    chk("rst_frz_state", 32'(state), 32'(RUN));
`ifdef HAZARD_PERF_EN
    chk("rst_cnts", stall_cnt | flush_cnt | freeze_cnt, 0);
`endif
    idle();
    step();
    rst = 0;
    step();
    chk("post_rst_ctl", 32'(ctl()), 0);
    chk("post_rst_state", 32'(state), 32'(RUN));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
